// File: rtl/pc_sequencer_if.sv
// Control bundle between a fetch front-end and the PC sequencer: redirect/trap/stack
// requests in, registered PC, stack status and one-cycle event pulses out.
interface pc_sequencer_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            trap;
    logic            ras_push;
    logic            ras_pop;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus;
    logic            ras_empty;
    logic            ras_full;
    logic            misaligned;
    logic            ras_underflow;

    modport master (
        output stall, redirect_valid, redirect_target, trap, ras_push, ras_pop,
        input  pc, pc_plus, ras_empty, ras_full, misaligned, ras_underflow
    );

    modport slave (
        input  stall, redirect_valid, redirect_target, trap, ras_push, ras_pop,
        output pc, pc_plus, ras_empty, ras_full, misaligned, ras_underflow
    );
endinterface

// File: rtl/pc_sequencer.sv
// PC sequencer: trap > redirect > stall > return-pop > increment, with a circular return-address stack.
// Latency: controls land on pc one edge later; backpressure: stall holds pc and freezes the stack.
module pc_sequencer #(
    parameter int              XLEN         = 32,
    parameter int              INC          = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int              RAS_DEPTH    = 4
) (
    input logic           clk,
    input logic           rst,
    pc_sequencer_if.slave bus
);
    localparam int              PTR_W   = $clog2(RAS_DEPTH);
    localparam int              CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  pc_nxt;
    logic [XLEN-1:0]  pc_plus;
    logic [XLEN-1:0]  ras_top;
    logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] top_ptr;
    logic [PTR_W-1:0] wr_idx;
    logic [CNT_W-1:0] count;
    logic             misaligned_q;
    logic             underflow_q;
    logic             seq_en;
    logic             redir_bad;
    logic             do_push;
    logic             do_pop;
    logic             pop_empty;

    assign pc_plus   = pc_q + XLEN'(INC);
    assign ras_top   = ras_mem[top_ptr];
    assign seq_en    = !bus.trap && !bus.redirect_valid && !bus.stall;
    assign redir_bad = bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00);
    assign do_pop    = seq_en && bus.ras_pop && (count != '0);
    assign pop_empty = seq_en && bus.ras_pop && (count == '0);
    assign do_push   = seq_en && bus.ras_push;
    // A push that coincides with a real pop replaces the top in place; otherwise it goes above it.
    assign wr_idx    = do_pop ? top_ptr : top_ptr + 1'b1;

    always_comb begin
        if (bus.trap || redir_bad) begin
            pc_nxt = TRAP_VECTOR;
        end else if (bus.redirect_valid) begin
            pc_nxt = bus.redirect_target;
        end else if (bus.stall) begin
            pc_nxt = pc_q;
        end else if (do_pop) begin
            pc_nxt = ras_top;
        end else begin
            pc_nxt = pc_plus;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q         <= RESET_VECTOR;
            top_ptr      <= '0;
            count        <= '0;
            misaligned_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            pc_q         <= pc_nxt;
            misaligned_q <= !bus.trap && redir_bad;
            underflow_q  <= pop_empty;
            // Pointer wraps naturally, so a push on a full stack overwrites the oldest entry.
            if (do_push && !do_pop) begin
                top_ptr <= top_ptr + 1'b1;
                if (count != CNT_MAX) begin
                    count <= count + 1'b1;
                end
            end else if (do_pop && !do_push) begin
                top_ptr <= top_ptr - 1'b1;
                count   <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            ras_mem[wr_idx] <= pc_plus;
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pc_plus       = pc_plus;
    assign bus.ras_empty     = (count == '0);
    assign bus.ras_full      = (count == CNT_MAX);
    assign bus.misaligned    = misaligned_q;
    assign bus.ras_underflow = underflow_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboarded bench for pc_sequencer: directed scenarios plus random control mix against a queue-based model.
module tb_pc_sequencer;
    localparam int          XLEN  = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] TRAPV = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst;

    pc_sequencer_if #(.XLEN(XLEN)) bus ();

    pc_sequencer #(
        .XLEN(XLEN), .INC(4), .RESET_VECTOR(32'h0), .TRAP_VECTOR(TRAPV), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        empty;
        logic        full;
        logic        mis;
        logic        und;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_pc;
    logic [31:0] m_stack[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Model: the stack is a plain queue, newest at the back; overflow drops the front.
    task automatic step(input logic tr, input logic rv, input logic [31:0] tgt,
                        input logic st, input logic pu, input logic po);
        exp_t        e;
        logic [31:0] nxt;
        logic        mis;
        logic        und;
        mis = 1'b0;
        und = 1'b0;
        bus.trap            = tr;
        bus.redirect_valid  = rv;
        bus.redirect_target = tgt;
        bus.stall           = st;
        bus.ras_push        = pu;
        bus.ras_pop         = po;
        if (tr) begin
            nxt = TRAPV;
        end else if (rv) begin
            if (tgt[1:0] != 2'b00) begin
                nxt = TRAPV;
                mis = 1'b1;
            end else begin
                nxt = tgt;
            end
        end else if (st) begin
            nxt = m_pc;
        end else if (po && m_stack.size() > 0) begin
            nxt = m_stack[m_stack.size()-1];
            if (pu) m_stack[m_stack.size()-1] = m_pc + 32'd4;
            else    void'(m_stack.pop_back());
        end else begin
            nxt = m_pc + 32'd4;
            if (po) und = 1'b1;
            if (pu) begin
                m_stack.push_back(m_pc + 32'd4);
                if (m_stack.size() > DEPTH) void'(m_stack.pop_front());
            end
        end
        m_pc    = nxt;
        e.pc    = nxt;
        e.empty = (m_stack.size() == 0);
        e.full  = (m_stack.size() == DEPTH);
        e.mis   = mis;
        e.und   = und;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic redirect(input logic [31:0] tgt);
        step(1'b0, 1'b1, tgt, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"}, bus.pc, 32'h0);
        check({tag, "_empty"}, bus.ras_empty, 1);
        check({tag, "_full"}, bus.ras_full, 0);
        check({tag, "_mis"}, bus.misaligned, 0);
        check({tag, "_und"}, bus.ras_underflow, 0);
    endtask

    // Monitor: the DUT presents a new state after every edge; compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc", bus.pc, e.pc);
                check("pc_plus", bus.pc_plus, e.pc + 32'd4);
                check("ras_empty", bus.ras_empty, e.empty);
                check("ras_full", bus.ras_full, e.full);
                check("misaligned", bus.misaligned, e.mis);
                check("ras_underflow", bus.ras_underflow, e.und);
            end
        end
    end

    initial begin
        rst                 = 1'b0;
        bus.trap            = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'h0;
        bus.stall           = 1'b0;
        bus.ras_push        = 1'b0;
        bus.ras_pop         = 1'b0;
        m_pc                = 32'h0;
        m_stack.delete();
        #3;
        check_reset_state("reset");
        @(negedge clk);
        rst = 1'b1;

        // Idle increment from the reset vector
        repeat (3) idle();

        // Trap wins over a simultaneous redirect
        redirect(32'h20);
        step(1'b1, 1'b1, 32'h400, 1'b0, 1'b0, 1'b0);

        // Misaligned redirect goes to the trap vector with a one-cycle pulse
        redirect(32'h40);
        redirect(32'h402);
        idle();

        // Fill past depth, then drain to underflow
        for (int k = 1; k <= 5; k++) begin
            redirect(32'h10 * k);
            step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        end
        repeat (5) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        idle();

        // Push and pop together swap the top entry
        redirect(32'h10);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        redirect(32'h80);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Push and pop together on an empty stack act as a push with underflow
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // PC wraps modulo 2^32
        redirect(32'hFFFF_FFFC);
        idle();

        // Stall blocks a pop
        redirect(32'h30);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        redirect(32'h60);
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

        // Asynchronous reset between edges, with controls pending
        #2;
        rst                 = 1'b0;
        bus.stall           = 1'b0;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h800;
        bus.ras_push        = 1'b1;
        bus.ras_pop         = 1'b1;
        #1;
        check_reset_state("async_reset");
        m_pc = 32'h0;
        m_stack.delete();
        @(negedge clk);
        check_reset_state("held_reset");
        rst = 1'b1;
        idle();

        // Random control mix
        for (int i = 0; i < 600; i++) begin
            logic [31:0] tgt;
            tgt = $urandom();
            if ($urandom_range(3) != 0) tgt[1:0] = 2'b00;
            step($urandom_range(15) == 0, $urandom_range(7) == 0, tgt,
                 $urandom_range(7) == 0, $urandom_range(2) == 0, $urandom_range(2) == 0);
        end

        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
